// File: rtl/spike_event_encoder.sv
// Serialises captured spike vectors into {timestamp, neuron_id} AER words for the event FIFO,
// tracking a free-running timestep and counting vectors lost to back-pressure.
module spike_event_encoder #(
    parameter int NUM_NEURONS = 16,
    parameter int ID_WIDTH    = 4,
    parameter int TS_WIDTH    = 16,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tick,
    input  logic                   spike_valid,
    input  logic [NUM_NEURONS-1:0] spike_in,
    input  logic                   fifo_full,
    output logic                   fifo_enq,
    output logic [DATA_WIDTH-1:0]  fifo_data,
    output logic                   busy,
    output logic [TS_WIDTH-1:0]    ts_now,
    output logic [15:0]            drop_count,
    output logic                   overflow
);

    typedef enum logic {
        IDLE,
        DRAIN
    } state_e;

    state_e                 state_q, state_d;
    logic [NUM_NEURONS-1:0] pending_q, pending_d;
    logic [TS_WIDTH-1:0]    batch_ts_q, batch_ts_d;
    logic [TS_WIDTH-1:0]    ts_q, ts_d;
    logic                   enq_q, enq_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic [15:0]            drop_q, drop_d;
    logic                   ovf_q, ovf_d;

    logic [ID_WIDTH-1:0]    pick_id;
    logic                   pick_found;
    logic [NUM_NEURONS-1:0] remaining;
    logic                   accept;

    // Priority encoder: scanning downward leaves the lowest set index as the winner.
    always_comb begin
        pick_id    = '0;
        pick_found = 1'b0;
        for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                pick_id    = ID_WIDTH'(i);
                pick_found = 1'b1;
            end
        end
        remaining = pending_q & ~(NUM_NEURONS'(1) << pick_id);
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        pending_d  = pending_q;
        batch_ts_d = batch_ts_q;
        ts_d       = tick ? ts_q + TS_WIDTH'(1) : ts_q;
        enq_d      = 1'b0;
        data_d     = data_q;
        drop_d     = drop_q;
        ovf_d      = ovf_q;
        accept     = 1'b0;

        case (state_q)
            IDLE: accept = spike_valid;
            DRAIN: begin
                if (pick_found && !fifo_full) begin
                    enq_d                          = 1'b1;
                    data_d                         = '0;
                    data_d[ID_WIDTH-1:0]           = pick_id;
                    data_d[ID_WIDTH +: TS_WIDTH]   = batch_ts_q;
                    pending_d                      = remaining;
                    if (remaining == '0) begin
                        state_d = IDLE;
                        accept  = spike_valid;
                    end
                end else if (!pick_found) begin
                    state_d = IDLE;
                    accept  = spike_valid;
                end
                if (spike_valid && !accept) begin
                    drop_d = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;
                    ovf_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A capture overrides the drain bookkeeping: the old vector is fully issued by then.
        if (accept) begin
            pending_d  = spike_in;
            batch_ts_d = ts_q;
            state_d    = (spike_in != '0) ? DRAIN : IDLE;
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            batch_ts_q <= '0;
            ts_q       <= '0;
            enq_q      <= 1'b0;
            data_q     <= '0;
            drop_q     <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            batch_ts_q <= batch_ts_d;
            ts_q       <= ts_d;
            enq_q      <= enq_d;
            data_q     <= data_d;
            drop_q     <= drop_d;
            ovf_q      <= ovf_d;
        end
    end

    assign fifo_enq   = enq_q;
    assign fifo_data  = data_q;
    assign busy       = (state_q == DRAIN);
    assign ts_now     = ts_q;
    assign drop_count = drop_q;
    assign overflow   = ovf_q;

endmodule
